// File: rtl/gcd_controller.sv
// Euclidean GCD sequencer driving a modulo_divisor stage through a start/done handshake.
// Optional iteration cap is enabled by defining GCD_ITER_LIMIT_EN.
module gcd_controller #(
    parameter int WIDTH    = 32,
    parameter int ITER_W   = 6,
    parameter int MAX_ITER = 47
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_a,
    input  logic [WIDTH-1:0]  in_b,
    output logic              md_start,
    output logic [WIDTH-1:0]  md_dividend,
    output logic [WIDTH-1:0]  md_divisor,
    input  logic [WIDTH-1:0]  md_remainder,
    input  logic              md_done,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_gcd,
    output logic [ITER_W-1:0] out_iters,
    output logic              out_err
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CHECK = 3'd1;
    localparam logic [2:0] ST_ISSUE = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_OUT   = 3'd4;

`ifdef GCD_ITER_LIMIT_EN
    localparam logic LIMIT_EN = 1'b1;
`else
    localparam logic LIMIT_EN = 1'b0;
`endif

    logic [2:0]        state_r;
    logic [WIDTH-1:0]  a_r;
    logic [WIDTH-1:0]  b_r;
    logic [ITER_W-1:0] iters_r;
    logic              in_ready_r;
    logic              md_start_r;
    logic [WIDTH-1:0]  md_dividend_r;
    logic [WIDTH-1:0]  md_divisor_r;
    logic              out_valid_r;
    logic [WIDTH-1:0]  out_gcd_r;
    logic [ITER_W-1:0] out_iters_r;
    logic              out_err_r;
    logic              cap_hit_s;

    function automatic logic [ITER_W-1:0] sat_inc(input logic [ITER_W-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + {{(ITER_W-1){1'b0}}, 1'b1};
        end
    endfunction

    // Iteration cap comparison; constant-false when the cap is compiled out
    always_comb begin
        cap_hit_s = 1'b0;
        if (LIMIT_EN && (iters_r == ITER_W'(MAX_ITER))) begin
            cap_hit_s = 1'b1;
        end else begin
            cap_hit_s = 1'b0;
        end
    end

    // Sequencer state, operand registers and registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            a_r           <= {WIDTH{1'b0}};
            b_r           <= {WIDTH{1'b0}};
            iters_r       <= {ITER_W{1'b0}};
            in_ready_r    <= 1'b1;
            md_start_r    <= 1'b0;
            md_dividend_r <= {WIDTH{1'b0}};
            md_divisor_r  <= {WIDTH{1'b0}};
            out_valid_r   <= 1'b0;
            out_gcd_r     <= {WIDTH{1'b0}};
            out_iters_r   <= {ITER_W{1'b0}};
            out_err_r     <= 1'b0;
        end else begin
            md_start_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (in_valid && in_ready_r) begin
                        a_r        <= in_a;
                        b_r        <= in_b;
                        iters_r    <= {ITER_W{1'b0}};
                        in_ready_r <= 1'b0;
                        state_r    <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (b_r == {WIDTH{1'b0}}) begin
                        out_gcd_r   <= a_r;
                        out_iters_r <= iters_r;
                        out_err_r   <= 1'b0;
                        out_valid_r <= 1'b1;
                        state_r     <= ST_OUT;
                    end else if (cap_hit_s) begin
                        out_gcd_r   <= {WIDTH{1'b0}};
                        out_iters_r <= iters_r;
                        out_err_r   <= 1'b1;
                        out_valid_r <= 1'b1;
                        state_r     <= ST_OUT;
                    end else begin
                        // b is non-zero here, so the divisor never sees a zero divisor
                        md_start_r    <= 1'b1;
                        md_dividend_r <= a_r;
                        md_divisor_r  <= b_r;
                        state_r       <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    state_r <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (md_done) begin
                        a_r     <= b_r;
                        b_r     <= md_remainder;
                        iters_r <= sat_inc(iters_r);
                        state_r <= ST_CHECK;
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_r;
    assign md_start    = md_start_r;
    assign md_dividend = md_dividend_r;
    assign md_divisor  = md_divisor_r;
    assign out_valid   = out_valid_r;
    assign out_gcd     = out_gcd_r;
    assign out_iters   = out_iters_r;
    assign out_err     = out_err_r;

endmodule

// File: tb/tb_gcd_controller.sv
// Directed bench for gcd_controller with a behavioural modulo divisor model.
// Build with GCD_ITER_LIMIT_EN defined to exercise the iteration cap (MAX_ITER=2).
module tb_gcd_controller;

    localparam int WIDTH  = 32;
    localparam int ITER_W = 6;
`ifdef GCD_ITER_LIMIT_EN
    localparam int MAX_ITER = 2;
    localparam bit LIMIT    = 1'b1;
`else
    localparam int MAX_ITER = 47;
    localparam bit LIMIT    = 1'b0;
`endif

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_a;
    logic [WIDTH-1:0]  in_b;
    logic              md_start;
    logic [WIDTH-1:0]  md_dividend;
    logic [WIDTH-1:0]  md_divisor;
    logic [WIDTH-1:0]  md_remainder;
    logic              md_done;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_gcd;
    logic [ITER_W-1:0] out_iters;
    logic              out_err;

    gcd_controller #(.WIDTH(WIDTH), .ITER_W(ITER_W), .MAX_ITER(MAX_ITER)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .md_start(md_start), .md_dividend(md_dividend), .md_divisor(md_divisor),
        .md_remainder(md_remainder), .md_done(md_done),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_gcd(out_gcd), .out_iters(out_iters), .out_err(out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // Divisor model: samples requests on the falling edge, answers after lat cycles
    int               lat       = 2;
    int               cnt       = 0;
    int               n_start   = 0;
    int               stab_err  = 0;
    int               late_done = 0;
    logic [WIDTH-1:0] cap_a     = '0;
    logic [WIDTH-1:0] cap_b     = '0;
    logic [WIDTH-1:0] log_a [8];
    logic [WIDTH-1:0] log_b [8];

    always @(negedge clk) begin
        md_done = 1'b0;
        if (md_start) begin
            if (n_start < 8) begin
                log_a[n_start] = md_dividend;
                log_b[n_start] = md_divisor;
            end
            n_start++;
            cap_a = md_dividend;
            cap_b = md_divisor;
            cnt   = lat;
            if (md_divisor == '0) stab_err++;
        end else if (cnt > 0) begin
            if (!in_ready && (md_dividend !== cap_a || md_divisor !== cap_b)) stab_err++;
            cnt--;
            if (cnt == 0) begin
                md_done      = 1'b1;
                md_remainder = (cap_b != '0) ? cap_a % cap_b : '0;
                if (in_ready) late_done++;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_in_ready"},  in_ready,    1);
        check({tag, "_md_start"},  md_start,    0);
        check({tag, "_md_divd"},   md_dividend, 0);
        check({tag, "_md_divs"},   md_divisor,  0);
        check({tag, "_out_valid"}, out_valid,   0);
        check({tag, "_out_gcd"},   out_gcd,     0);
        check({tag, "_out_iters"}, out_iters,   0);
        check({tag, "_out_err"},   out_err,     0);
    endtask

    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int t = 0;
        while (!in_ready && t < 200) begin
            tick();
            t++;
        end
        check("accept_ready", in_ready, 1);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        tick();
        in_valid = 1'b0;
        check("busy_in_ready", in_ready, 0);
    endtask

    task automatic wait_out();
        int t = 0;
        while (!out_valid && t < 400) begin
            tick();
            t++;
        end
        check("out_valid_seen", out_valid, 1);
    endtask

    task automatic expect_result(input string tag, input int g, input int it);
        int eg = g;
        int ei = it;
        int ee = 0;
        if (LIMIT && it > MAX_ITER) begin
            eg = 0;
            ei = MAX_ITER;
            ee = 1;
        end
        check({tag, "_gcd"},   out_gcd,   eg);
        check({tag, "_iters"}, out_iters, ei);
        check({tag, "_err"},   out_err,   ee);
    endtask

    task automatic take();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("take_valid_drop", out_valid, 0);
        check("take_in_ready",   in_ready,  1);
    endtask

    task automatic run(input string tag, input int a, input int b, input int g, input int it);
        send(a, b);
        wait_out();
        expect_result(tag, g, it);
        take();
    endtask

    int base;
    int exp_p;
    int prev;
    int t;
    logic [WIDTH-1:0] t1_a [3];
    logic [WIDTH-1:0] t1_b [3];

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
        md_done = 1'b0; md_remainder = '0;
        t1_a[0] = 48; t1_b[0] = 18;
        t1_a[1] = 18; t1_b[1] = 12;
        t1_a[2] = 12; t1_b[2] = 6;
        tick();
        tick();
        check_reset("rst");
        rst_n = 1'b1;
        tick();
        check("post_rst_ready", in_ready, 1);

        // (48,18): three divisor requests with rotating operands
        base = n_start;
        run("t48_18", 48, 18, 6, 3);
        exp_p = (LIMIT && MAX_ITER < 3) ? MAX_ITER : 3;
        check("t48_18_pulses", n_start - base, exp_p);
        for (int i = 0; i < exp_p; i++) begin
            check("t48_18_dividend", log_a[base + i], t1_a[i]);
            check("t48_18_divisor",  log_b[base + i], t1_b[i]);
        end

        // a<b: first request only swaps
        base = n_start;
        run("t18_48", 18, 48, 6, 4);
        check("t18_48_first_dividend", log_a[base], 18);
        check("t18_48_first_divisor",  log_b[base], 48);

        // boundaries with a zero operand
        base = n_start;
        send(0, 0);
        tick();
        check("t0_0_latency", out_valid, 1);
        expect_result("t0_0", 0, 0);
        take();
        check("t0_0_no_start", n_start - base, 0);
        run("t7_0", 7, 0, 7, 0);
        run("t0_5", 0, 5, 5, 1);

        // back-pressure on the result, then simultaneous out_ready and in_valid
        send(35, 10);
        wait_out();
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_valid",    out_valid, 1);
            check("hold_gcd",      out_gcd,   5);
            check("hold_in_ready", in_ready,  0);
        end
        expect_result("t35_10", 5, 2);
        in_valid = 1'b1; in_a = 9; in_b = 6; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("simul_valid_drop", out_valid, 0);
        check("simul_not_taken",  in_ready,  1);
        tick();
        in_valid = 1'b0;
        check("simul_taken_idle", in_ready, 0);
        wait_out();
        expect_result("t9_6", 3, 2);
        take();

        // reset during WAIT; the late divisor answer must be ignored
        lat = 6;
        prev = n_start;
        send(48, 18);
        t = 0;
        while (n_start == prev && t < 50) begin
            tick();
            t++;
        end
        check("mid_start_seen", n_start - prev, 1);
        tick();
        rst_n = 1'b0;
        #1;
        check_reset("mid_rst");
        tick();
        rst_n = 1'b1;
        prev = late_done;
        for (int i = 0; i < 8; i++) tick();
        check("late_done_seen", late_done - prev, 1);
        check("late_out_valid", out_valid, 0);
        check("late_in_ready",  in_ready,  1);
        lat = 2;
        run("t21_14", 21, 14, 7, 2);

        check("md_stable", stab_err, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
